// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// WIDTH iterations per op with a Busy/Done handshake and single-cycle special cases.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic [2:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             IsMulDiv,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [WIDTH-1:0]     a_mag, a_mag_n, b_mag, b_mag_n, result_n;
  logic [2*WIDTH-1:0]   acc, acc_n, step, prod;
  logic                 neg, neg_n, hi_sel, hi_sel_n;
  logic                 is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic                 div_zero, div_ovf, accept, last, ge;
  logic [WIDTH-1:0]     a_abs, b_abs, r_new, res_val;
  logic [WIDTH:0]       mul_sum, r_shift;

  assign IsMulDiv = (ALUOp == 3'b010) && (Funct7 == 7'b0000001);
  assign Busy     = (state != IDLE);
  assign Done     = (state == DONE);

  always_comb begin
    is_div   = Funct3[2];
    sgn_a    = is_div ? !Funct3[0] : (Funct3 != 3'b011);
    sgn_b    = is_div ? !Funct3[0] : !Funct3[1];
    a_neg    = sgn_a & SrcA[WIDTH-1];
    b_neg    = sgn_b & SrcB[WIDTH-1];
    a_abs    = a_neg ? -SrcA : SrcA;
    b_abs    = b_neg ? -SrcB : SrcB;
    div_zero = is_div && (SrcB == '0);
    div_ovf  = is_div && !Funct3[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
    accept   = Start && IsMulDiv && (state == IDLE) && !Flush;
    last     = (cnt == CW'(WIDTH-1));

    // acc: MUL = {partial product, remaining multiplier}; DIV = {remainder, dividend/quotient}
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    r_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge       = (r_shift >= {1'b0, b_mag});
    r_new    = ge ? WIDTH'(r_shift - {1'b0, b_mag}) : r_shift[WIDTH-1:0];
    step     = (state == MUL) ? {mul_sum, acc[WIDTH-1:1]}
                              : {r_new, acc[WIDTH-2:0], ge};
    prod     = neg ? -step : step;
    res_val  = hi_sel ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];

    state_n  = state;
    cnt_n    = cnt;
    a_mag_n  = a_mag;
    b_mag_n  = b_mag;
    acc_n    = acc;
    neg_n    = neg;
    hi_sel_n = hi_sel;
    result_n = Result;

    if (Flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_mag_n  = a_abs;
          b_mag_n  = b_abs;
          cnt_n    = '0;
          hi_sel_n = is_div ? Funct3[1] : (Funct3 != 3'b000);
          neg_n    = (is_div && Funct3[1]) ? a_neg : (a_neg ^ b_neg);
          if (div_zero) begin
            result_n = Funct3[1] ? SrcA : '1;
            state_n  = DONE;
          end else if (div_ovf) begin
            result_n = Funct3[1] ? '0 : SrcA;
            state_n  = DONE;
          end else begin
            acc_n   = is_div ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
            state_n = is_div ? DIV : MUL;
          end
        end
        MUL, DIV: begin
          acc_n = step;
          cnt_n = cnt + CW'(1);
          if (last) begin
            state_n = DONE;
            if (state == MUL)
              result_n = hi_sel ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
            else
              result_n = neg ? -res_val : res_val;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      hi_sel <= 1'b0;
      Result <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      a_mag  <= a_mag_n;
      b_mag  <= b_mag_n;
      acc    <= acc_n;
      neg    <= neg_n;
      hi_sel <= hi_sel_n;
      Result <= result_n;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random RV32M ops against an
// arithmetic reference model, plus flush, decode and asynchronous-reset cases.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, Start, Flush;
  logic [2:0]  ALUOp, Funct3;
  logic [6:0]  Funct7;
  logic [31:0] SrcA, SrcB, Result;
  logic        IsMulDiv, Busy, Done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] last_result = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .ALUOp(ALUOp),
    .Funct7(Funct7), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .IsMulDiv(IsMulDiv), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    if (f3[2] && b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: return 32'(sa / sb);
      3'd5: return 32'(ua / ub);
      3'd6: return 32'(sa % sb);
      default: return 32'(ua % ub);
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp, got;
    int unsigned exp_cyc, done_at, busy_bad;
    exp     = ref_op(f3, a, b);
    exp_cyc = is_special(f3, a, b) ? 1 : 33;
    got     = 'x;
    @(negedge clk);
    Start = 1'b1; ALUOp = 3'b010; Funct7 = 7'b0000001; Funct3 = f3; SrcA = a; SrcB = b;
    @(negedge clk);
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
    done_at = 0; busy_bad = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (Busy !== 1'b1) busy_bad++;
      if (Done === 1'b1) begin done_at = c; got = Result; end
    end
    check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_cyc));
    check({tag, "_result"}, 64'(got), 64'(exp));
    check({tag, "_busy_low"}, 64'(busy_bad), 64'd0);
    @(negedge clk);
    check({tag, "_idle_after"}, 64'(Busy), 64'd0);
    last_result = exp;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int unsigned seen;
    reset = 1'b1; Start = 1'b0; Flush = 1'b0; ALUOp = 3'b010; Funct7 = 7'b0000001;
    Funct3 = 3'b000; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_result", 64'(Result), 64'd0);
    check("decode_muldiv", 64'(IsMulDiv), 64'd1);
    reset = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
    run_op(3'd5, 32'd100, 32'd7, "divu");
    run_op(3'd7, 32'd100, 32'd7, "remu");

    // asynchronous reset in cycle 5 of a divide
    @(negedge clk);
    Start = 1'b1; Funct7 = 7'b0000001; Funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(Busy), 64'd0);
    check("async_rst_done", 64'(Done), 64'd0);
    check("async_rst_result", 64'(Result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd4, 32'd1000, 32'd3, "div_after_rst");

    run_op(3'd5, 32'd5, 32'd0, "divu_by0");
    run_op(3'd6, 32'd5, 32'd0, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(3'd3, 32'd12345, 32'd678, "mulhu_small");

    // flush in cycle 10 of a multiply
    @(negedge clk);
    Start = 1'b1; Funct7 = 7'b0000001; Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd11;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check("flush_busy", 64'(Busy), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done === 1'b1) seen++;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_result_kept", 64'(Result), 64'(last_result));

    // Start together with Flush
    @(negedge clk);
    Start = 1'b1; Flush = 1'b1; Funct3 = 3'd5; SrcA = 32'd50; SrcB = 32'd0;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    check("start_flush_busy", 64'(Busy), 64'd0);
    check("start_flush_done", 64'(Done), 64'd0);

    // non-M instruction
    @(negedge clk);
    Start = 1'b1; Funct7 = 7'b0000000; Funct3 = 3'd0;
    #1 check("decode_not_muldiv", 64'(IsMulDiv), 64'd0);
    @(negedge clk);
    Start = 1'b0; Funct7 = 7'b0000001;
    check("non_m_busy", 64'(Busy), 64'd0);
    check("non_m_result_kept", 64'(Result), 64'(last_result));

    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(f3, a, b, $sformatf("rand%0d_f%0d", i, f3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
